// File: rtl/txr_to_noc_rr_pkg.sv
// Shared types and width helpers for the Avalon-ST to NoC injector.
package txr_noc_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PKT  = 1'b1
    } state_e;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int credit_w(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/txr_to_noc_rr_chk.sv
// Simulation checker: a credit return must never push a VC above its reset allowance.
module txr_to_noc_rr_chk #(
    parameter int NUM_VC = 2
) (
    input logic              clk,
    input logic              rst_n,
    input logic [NUM_VC-1:0] ovf_i
);
    // Flag any return that was discarded because the VC was already full
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (ovf_i == {NUM_VC{1'b0}})
            else $error("credit return beyond VC_CREDITS, vc mask %b", ovf_i);
        end
    end

endmodule

// File: rtl/txr_to_noc_rr_fifo.sv
// Synchronous FIFO of flit structs; pointers carry one wrap bit for full/empty.
module pkt_fifo_sync
    import txr_noc_pkg::*;
#(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic wr_en_i,
    input  T     wr_data_i,
    input  logic rd_en_i,
    output T     rd_data_o,
    output logic full_o,
    output logic empty_o
);
    localparam int AW = ptr_w(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        wr_fire_s, rd_fire_s;
    T            mem_q [DEPTH];

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_fire_s = wr_en_i & ~full_o;
    assign rd_fire_s = rd_en_i & ~empty_o;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance
    always_comb begin
        wr_ptr_d = wr_fire_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = rd_fire_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    end

    // Pointer registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= {(AW + 1){1'b0}};
            rd_ptr_q <= {(AW + 1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents are meaningless until the pointers say otherwise
    always_ff @(posedge clk_i) begin
        if (wr_fire_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/txr_to_noc_rr.sv
// Buffers an Avalon-ST packet stream and injects it into the NoC with round-robin
// destination and VC selection under per-VC flit credit flow control.
module txr_to_noc_rr
    import txr_noc_pkg::*;
#(
    parameter  int DATA_WIDTH = 512,
    parameter  int NUM_VC     = 2,
    parameter  int NOC_RADIX  = 16,
    parameter  int NUM_DST    = 4,
    parameter  int DST_BASE   = 0,
    parameter  int VC_CREDITS = 8,
    parameter  int FIFO_DEPTH = 4,
    localparam int EMPTY_W    = ptr_w(DATA_WIDTH / 8),
    localparam int VC_W       = ptr_w(NUM_VC),
    localparam int DST_W      = ptr_w(NOC_RADIX)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic [EMPTY_W-1:0]    in_empty,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [EMPTY_W-1:0]    out_empty,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic [NUM_VC-1:0]     i_credit_return,
    output logic [VC_W-1:0]       o_vc_id,
    output logic [DST_W-1:0]      o_noc_dst,
    output logic [31:0]           o_pkt_count,
    output logic [31:0]           o_drop_count
);
    localparam int CRED_W = credit_w(VC_CREDITS);
    localparam int DPTR_W = ptr_w(NUM_DST);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(VC_CREDITS);
    localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);

    typedef struct packed {
        logic                  sop;
        logic                  eop;
        logic [EMPTY_W-1:0]    empty;
        logic [DATA_WIDTH-1:0] data;
    } flit_t;

    flit_t               wr_flit_s, head_s;
    logic                full_s, empty_s, push_s, pop_s;
    logic                send_s, drop_s, start_s, vc_found_s;
    logic [VC_W-1:0]     vc_sel_s, vc_idx_s;
    logic [NUM_VC-1:0]   ovf_s;
    state_e              state_q, state_d;
    logic [CRED_W-1:0]   credit_q [NUM_VC];
    logic [CRED_W-1:0]   credit_d [NUM_VC];
    logic [VC_W-1:0]     vc_q, vc_d, vc_ptr_q, vc_ptr_d;
    logic [DPTR_W-1:0]   dst_ptr_q, dst_ptr_d;
    logic [DST_W-1:0]    dst_q, dst_d;
    logic [31:0]         pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;

    assign in_ready  = reset & ~full_s;
    assign push_s    = in_valid & in_ready;
    assign wr_flit_s = {in_sop, in_eop, in_empty, in_data};
    assign send_s    = out_valid & out_ready;
    assign pop_s     = send_s | drop_s;

    assign out_sop      = head_s.sop;
    assign out_eop      = head_s.eop;
    assign out_empty    = head_s.empty;
    assign out_data     = head_s.data;
    assign o_vc_id      = vc_q;
    assign o_noc_dst    = dst_q;
    assign o_pkt_count  = pkt_cnt_q;
    assign o_drop_count = drop_cnt_q;

    pkt_fifo_sync #(.T(flit_t), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i     (clk),
        .rst_n_i   (reset),
        .wr_en_i   (push_s),
        .wr_data_i (wr_flit_s),
        .rd_en_i   (pop_s),
        .rd_data_o (head_s),
        .full_o    (full_s),
        .empty_o   (empty_s)
    );

    // First VC holding credit, searching upward from vc_ptr; lowest offset wins
    always_comb begin
        vc_found_s = 1'b0;
        vc_sel_s   = {VC_W{1'b0}};
        vc_idx_s   = {VC_W{1'b0}};
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            vc_idx_s   = VC_W'((int'(vc_ptr_q) + k) % NUM_VC);
            vc_found_s = vc_found_s | (credit_q[vc_idx_s] != {CRED_W{1'b0}});
            vc_sel_s   = (credit_q[vc_idx_s] != {CRED_W{1'b0}}) ? vc_idx_s : vc_sel_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = (!empty_s && head_s.sop && vc_found_s) ? S_PKT : S_IDLE;
            S_PKT:   state_d = (send_s && head_s.eop) ? S_IDLE : S_PKT;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: drop stray heads in idle, stream under credit in a packet
    always_comb begin
        out_valid = 1'b0;
        drop_s    = 1'b0;
        start_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                drop_s  = !empty_s && !head_s.sop;
                start_s = !empty_s && head_s.sop && vc_found_s;
            end
            S_PKT: begin
                out_valid = !empty_s && (credit_q[vc_q] != {CRED_W{1'b0}});
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    // Packet bookkeeping: latch routing on start, advance pointers on EOP
    always_comb begin
        vc_d       = vc_q;
        dst_d      = dst_q;
        vc_ptr_d   = vc_ptr_q;
        dst_ptr_d  = dst_ptr_q;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (start_s) begin
            vc_d  = vc_sel_s;
            dst_d = DST_W'(DST_BASE) + DST_W'(dst_ptr_q);
        end else begin
            vc_d  = vc_q;
            dst_d = dst_q;
        end
        if (send_s && head_s.eop) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
            dst_ptr_d = (dst_ptr_q == DPTR_W'(NUM_DST - 1)) ? {DPTR_W{1'b0}} : dst_ptr_q + DPTR_W'(1);
            vc_ptr_d  = (vc_q == VC_W'(NUM_VC - 1)) ? {VC_W{1'b0}} : vc_q + VC_W'(1);
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end
        if (drop_s) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Credit update: a same-cycle send and return cancel out
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            credit_d[v] = credit_q[v];
            ovf_s[v]    = 1'b0;
            if (i_credit_return[v] && !(send_s && vc_q == VC_W'(v))) begin
                ovf_s[v]    = (credit_q[v] == CRED_MAX);
                credit_d[v] = (credit_q[v] == CRED_MAX) ? credit_q[v] : credit_q[v] + CRED_ONE;
            end else if (!i_credit_return[v] && send_s && vc_q == VC_W'(v)) begin
                credit_d[v] = credit_q[v] - CRED_ONE;
            end else begin
                credit_d[v] = credit_q[v];
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vc_q       <= {VC_W{1'b0}};
            dst_q      <= DST_W'(DST_BASE);
            vc_ptr_q   <= {VC_W{1'b0}};
            dst_ptr_q  <= {DPTR_W{1'b0}};
            pkt_cnt_q  <= 32'd0;
            drop_cnt_q <= 32'd0;
            for (int v = 0; v < NUM_VC; v++) begin
                credit_q[v] <= CRED_MAX;
            end
        end else begin
            vc_q       <= vc_d;
            dst_q      <= dst_d;
            vc_ptr_q   <= vc_ptr_d;
            dst_ptr_q  <= dst_ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            for (int v = 0; v < NUM_VC; v++) begin
                credit_q[v] <= credit_d[v];
            end
        end
    end

    txr_to_noc_rr_chk #(.NUM_VC(NUM_VC)) u_chk (
        .clk   (clk),
        .rst_n (reset),
        .ovf_i (ovf_s)
    );

endmodule

// File: tb/tb_txr_to_noc_rr.sv
// Directed bench for txr_to_noc_rr with default parameters (2 VCs, 4 destinations, 8 credits).
module tb_txr_to_noc_rr;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_sop = 1'b0;
    logic         in_eop = 1'b0;
    logic [5:0]   in_empty = 6'd0;
    logic [511:0] in_data = 512'd0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_sop;
    logic         out_eop;
    logic [5:0]   out_empty;
    logic [511:0] out_data;
    logic [1:0]   i_credit_return = 2'b00;
    logic         o_vc_id;
    logic [3:0]   o_noc_dst;
    logic [31:0]  o_pkt_count;
    logic [31:0]  o_drop_count;

    typedef struct {
        logic        sop;
        logic        eop;
        logic [63:0] d;
    } fin_t;

    typedef struct {
        logic        sop;
        logic        eop;
        logic [5:0]  e;
        logic [63:0] d;
        logic        vc;
        logic [3:0]  dst;
    } fout_t;

    fin_t       in_arr[$];
    fout_t      cap[$];
    int         in_rd = 0;
    logic [1:0] man_ret = 2'b00;
    logic [1:0] ret_pend = 2'b00;
    logic       auto_ret = 1'b1;
    int         ready_mode = 0;
    int         hold_err = 0;
    int         full_cyc = 0;
    logic       prev_stall = 1'b0;
    logic [63:0] prev_d = 64'd0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    txr_to_noc_rr dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_sop          (in_sop),
        .in_eop          (in_eop),
        .in_empty        (in_empty),
        .in_data         (in_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_sop         (out_sop),
        .out_eop         (out_eop),
        .out_empty       (out_empty),
        .out_data        (out_data),
        .i_credit_return (i_credit_return),
        .o_vc_id         (o_vc_id),
        .o_noc_dst       (o_noc_dst),
        .o_pkt_count     (o_pkt_count),
        .o_drop_count    (o_drop_count)
    );

    // Driver: all DUT inputs except reset change just after the rising edge
    always begin
        @(posedge clk);
        #1;
        i_credit_return = man_ret | (auto_ret ? ret_pend : 2'b00);
        if (in_rd < in_arr.size()) begin
            in_valid = 1'b1;
            in_sop   = in_arr[in_rd].sop;
            in_eop   = in_arr[in_rd].eop;
            in_data  = 512'(in_arr[in_rd].d);
            in_empty = in_arr[in_rd].d[5:0];
        end else begin
            in_valid = 1'b0;
        end
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor on the falling edge: records handshakes that complete at the next rising edge
    always @(negedge clk) begin
        ret_pend = 2'b00;
        if (!reset) begin
            in_rd = in_arr.size();
        end else if (in_valid && in_ready) begin
            in_rd++;
        end
        if (reset && in_valid && !in_ready) full_cyc++;
        if (prev_stall && !(out_valid && out_data[63:0] == prev_d)) hold_err++;
        prev_stall = out_valid && !out_ready;
        prev_d     = out_data[63:0];
        if (out_valid && out_ready) begin
            cap.push_back('{sop: out_sop, eop: out_eop, e: out_empty, d: out_data[63:0],
                            vc: o_vc_id, dst: o_noc_dst});
            ret_pend[o_vc_id] = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic push_pkt(input int n, input logic [63:0] base, input logic sop0);
        fin_t f;
        for (int i = 0; i < n; i++) begin
            f.sop = (i == 0) && sop0;
            f.eop = (i == n - 1);
            f.d   = base + 64'(i);
            in_arr.push_back(f);
        end
    endtask

    task automatic wait_cap(input int n);
        int t;
        t = 0;
        while (cap.size() < n && t < 400) begin
            tick();
            t++;
        end
        check("flit_count", 64'(cap.size()), 64'(n));
    endtask

    task automatic chk_pkt(input string tag, input int idx, input int n, input logic [63:0] base,
                           input logic vc, input logic [3:0] dst);
        logic [63:0] ed, got, exp;
        for (int i = 0; i < n; i++) begin
            ed  = base + 64'(i);
            got = 64'hFFFF_FFFF_FFFF_FFFF;
            if (idx + i < cap.size()) begin
                got = {19'd0, cap[idx+i].sop, cap[idx+i].eop, cap[idx+i].vc, cap[idx+i].dst,
                       cap[idx+i].e, cap[idx+i].d[31:0]};
            end
            exp = {19'd0, (i == 0), (i == n - 1), vc, dst, ed[5:0], ed[31:0]};
            check(tag, got, exp);
        end
    endtask

    initial begin
        int fb;
        // Reset state
        repeat (3) tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_vc", 64'(o_vc_id), 64'd0);
        check("rst_dst", 64'(o_noc_dst), 64'd0);
        check("rst_pkt_cnt", 64'(o_pkt_count), 64'd0);
        check("rst_drop_cnt", 64'(o_drop_count), 64'd0);
        reset = 1'b1;
        tick();

        // Single-flit packets rotate destinations and VCs
        for (int p = 0; p < 6; p++) push_pkt(1, 64'(100 + p), 1'b1);
        wait_cap(6);
        for (int p = 0; p < 6; p++) chk_pkt("t1_pkt", p, 1, 64'(100 + p), 1'(p % 2), 4'(p % 4));
        repeat (3) tick();
        check("t1_pkt_cnt", 64'(o_pkt_count), 64'd6);

        // Credit exhaustion on VC0, released one flit per returned credit
        auto_ret = 1'b0;
        push_pkt(10, 64'd200, 1'b1);
        wait_cap(14);
        repeat (10) tick();
        check("t2_stalled_cnt", 64'(cap.size()), 64'd14);
        check("t2_stalled_valid", 64'(out_valid), 64'd0);
        man_ret = 2'b01;
        tick();
        man_ret = 2'b00;
        repeat (10) tick();
        check("t2_one_more", 64'(cap.size()), 64'd15);
        man_ret = 2'b01;
        tick();
        man_ret = 2'b00;
        wait_cap(16);
        chk_pkt("t2_pkt", 6, 10, 64'd200, 1'b0, 4'd2);
        repeat (3) tick();
        check("t2_pkt_cnt", 64'(o_pkt_count), 64'd7);

        // VC0 still empty: both packets must skip to VC1, then vc_ptr wraps to 0
        auto_ret = 1'b1;
        push_pkt(1, 64'd300, 1'b1);
        push_pkt(3, 64'd310, 1'b1);
        wait_cap(20);
        chk_pkt("t3_single", 16, 1, 64'd300, 1'b1, 4'd3);
        chk_pkt("t3_skip", 17, 3, 64'd310, 1'b1, 4'd0);
        repeat (3) tick();
        man_ret = 2'b01;
        repeat (8) tick();
        man_ret = 2'b00;
        repeat (2) tick();
        push_pkt(1, 64'd320, 1'b1);
        wait_cap(21);
        chk_pkt("t3_vcptr", 20, 1, 64'd320, 1'b0, 4'd1);

        // Backpressure with out_ready toggling every cycle
        repeat (3) tick();
        fb = full_cyc;
        hold_err = 0;
        ready_mode = 1;
        push_pkt(4, 64'd500, 1'b1);
        push_pkt(4, 64'd510, 1'b1);
        push_pkt(4, 64'd520, 1'b1);
        wait_cap(33);
        chk_pkt("t5_p0", 21, 4, 64'd500, 1'b1, 4'd2);
        chk_pkt("t5_p1", 25, 4, 64'd510, 1'b0, 4'd3);
        chk_pkt("t5_p2", 29, 4, 64'd520, 1'b1, 4'd0);
        check("t5_in_ready_low", 64'(full_cyc > fb), 64'd1);
        check("t5_hold_stable", 64'(hold_err), 64'd0);
        ready_mode = 0;
        repeat (4) tick();
        check("t5_pkt_cnt", 64'(o_pkt_count), 64'd13);

        // Reset during flit 2 of 5, then a malformed head and a full-credit packet
        auto_ret = 1'b0;
        push_pkt(5, 64'd600, 1'b1);
        wait_cap(35);
        reset = 1'b0;
        #1;
        check("t6_valid_in_rst", 64'(out_valid), 64'd0);
        check("t6_ready_in_rst", 64'(in_ready), 64'd0);
        repeat (2) tick();
        check("t6_pkt_cnt_rst", 64'(o_pkt_count), 64'd0);
        check("t6_dst_rst", 64'(o_noc_dst), 64'd0);
        check("t6_vc_rst", 64'(o_vc_id), 64'd0);
        reset = 1'b1;
        repeat (2) tick();
        check("t6_no_stray", 64'(cap.size()), 64'd35);
        push_pkt(1, 64'd700, 1'b0);
        push_pkt(8, 64'd710, 1'b1);
        wait_cap(43);
        chk_pkt("t6_pkt", 35, 8, 64'd710, 1'b0, 4'd0);
        repeat (3) tick();
        check("t4_drop_cnt", 64'(o_drop_count), 64'd1);
        check("t6_pkt_cnt", 64'(o_pkt_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/txr_to_noc_rr.md
Name: txr_to_noc_rr

Overview:
- Parametrised successor to txr_to_noc_basic.
- Takes an Avalon-ST packet stream and buffers it in a small FIFO.
- Assigns each packet a NoC destination by round-robin over a configurable destination range, and a virtual channel by round-robin over VCs that hold credit.
- Forwards flits under per-VC credit flow control. Sits between the packet source (pcap reader / MAC side) and the NoC injection port.

Parameters:
- DATA_WIDTH, 512, Avalon-ST data width; multiple of 64.
- NUM_VC, 2, number of NoC virtual channels; ≥1.
- NOC_RADIX, 16, number of NoC routers; sets the o_noc_dst width.
- NUM_DST, 4, number of destinations in the round-robin range; 1..NOC_RADIX.
- DST_BASE, 0, first destination router; DST_BASE+NUM_DST ≤ NOC_RADIX.
- VC_CREDITS, 8, flit credits per VC at reset.
- FIFO_DEPTH, 4, input FIFO entries; power of 2, ≥2.

Ports:
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-low reset.
- in  avalonST sink  DATA_WIDTH  packet input (valid, ready, sop, eop, empty, data).
- out  avalonST source  DATA_WIDTH  flits to NoC.
- i_credit_return  input  NUM_VC  one-cycle pulse per bit; returns one flit credit to that VC.
- o_vc_id  output  $clog2(NUM_VC)  VC of the current output packet.
- o_noc_dst  output  $clog2(NOC_RADIX)  destination of the current output packet.
- o_pkt_count  output  32  packets fully sent (EOP handshakes).
- o_drop_count  output  32  flits dropped as malformed.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO emptied; state S_IDLE.
  - All credits = VC_CREDITS; dst_ptr=0; vc_ptr=0.
  - o_vc_id=0, o_noc_dst=DST_BASE, out.valid=0, counters=0.
  - in.ready=0 while reset is asserted.
  - Reset mid-packet discards the partial packet; no EOP is emitted.
- Input side:
  - in.ready = !fifo_full. A flit is written when in.valid && in.ready.
  - Simultaneous read and write while full is not allowed, because ready is deasserted when full.
- S_IDLE:
  - Head flit with sop=0: pop it and increment o_drop_count. out.valid stays 0.
  - Head flit with sop=1 and at least one VC with credit>0: latch vc_r = first VC with credit, searching from vc_ptr upward with wrap. Latch dst_r = DST_BASE+dst_ptr. Go to S_PKT.
  - Head flit with sop=1 and all credits 0: stay in S_IDLE.
- S_PKT:
  - out.valid = fifo_nonempty && credit[vc_r]>0.
  - out.sop/eop/empty/data come from the FIFO head.
  - o_vc_id=vc_r and o_noc_dst=dst_r, held constant for the whole packet.
  - On handshake (out.valid && out.ready): pop the FIFO and decrement credit[vc_r].
  - On an eop handshake:
    - increment o_pkt_count;
    - dst_ptr = (dst_ptr==NUM_DST-1) ? 0 : dst_ptr+1;
    - vc_ptr = (vc_r==NUM_VC-1) ? 0 : vc_r+1;
    - return to S_IDLE.
  - A second sop before eop is forwarded unchanged. No repair is done.
- Latency: a flit written to an empty FIFO at edge t is presented at out no earlier than t+2 (one cycle in FIFO, one cycle for IDLE selection). Subsequent flits of the same packet stream at 1 flit/cycle.
- Credits:
  - Per VC, width $clog2(VC_CREDITS+1).
  - A return and a send on the same VC in the same cycle leave the count unchanged.
  - A return that would exceed VC_CREDITS is ignored and flagged by a simulation assertion.
  - A return on another VC during a stall unblocks only that VC.
- Counters wrap modulo 2^32.
- out.ready low holds out.valid and data stable (Avalon-ST rules).

Decomposition:
- Package txr_noc_pkg:
  - state enum (S_IDLE, S_PKT);
  - credit-width and pointer-width localparam functions;
  - flit struct {sop, eop, empty, data} parametrised by DATA_WIDTH via a typedef in the module.
- Sub-module pkt_fifo_sync: synchronous FIFO of flit structs with full/empty flags and asynchronous active-low reset.
- Top contains the FSM, credit counters, round-robin pointers and statistics.

Test Plan:
1. Single-flit packets:
   - Stimulus: 6 single-flit packets (sop=eop=1), out.ready=1, credits returned immediately.
   - Response: o_noc_dst sequence 0,1,2,3,0,1; o_vc_id 0,1,0,1,0,1; o_pkt_count=6.
2. Credit exhaustion:
   - Stimulus: one 10-flit packet, VC_CREDITS=8, no returns.
   - Response: 8 flits sent, out.valid drops to 0; one i_credit_return[0] pulse releases exactly flit 9.
3. VC skip:
   - Stimulus: credit[0]=0, credit[1]=8, 3-flit packet arrives.
   - Response: packet sent on VC 1 with no stall; vc_ptr then points to 0.
4. Malformed head:
   - Stimulus: flit with sop=0 arrives while in S_IDLE, followed by a valid 2-flit packet.
   - Response: o_drop_count=1; the packet is output intact with o_noc_dst=0.
5. Backpressure:
   - Stimulus: 4-flit packets streamed in with out.ready toggled 1,0,1,0.
   - Response: in.ready low once 4 flits are buffered; no flit lost or duplicated; data order preserved.
6. Mid-packet reset:
   - Stimulus: reset asserted during flit 2 of 5.
   - Response: out.valid=0 immediately; credits=8; the next packet starts with o_noc_dst=DST_BASE and o_vc_id=0.
